// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
//   APB3 requester. Takes one read/write command over a valid/ready port, runs
//   the two-phase APB transfer (SETUP, then ACCESS held until pready) and returns
//   read data and error status over a valid/ready response port. Only one command
//   is outstanding at a time.
//
//   Optional feature macro: APB_MST_TIMEOUT_EN
//     When defined, an ACCESS phase that sees TIMEOUT_CYC consecutive cycles with
//     pready low is aborted and answered with rsp_err=1, rsp_rdata=0.
//     When undefined, ACCESS waits for pready indefinitely.
// -----------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    // APB requester port
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // The abort counter needs at least one wait cycle to be meaningful.
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("apb_cmd_master: TIMEOUT_CYC must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;

`ifdef APB_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    // Counts completed ACCESS cycles that saw pready low.
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
`endif

    // Next-state and next-output decode; every output is produced from a register.
    always_comb begin
        // NOTE: every _d starts as its _q so each path is fully assigned and no latch is inferred.
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
`ifdef APB_MST_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                // Bus fields only change on accept, so they stay quiet between transfers.
                if (cmd_valid) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    psel_d      = 1'b1;
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_write ? cmd_wdata : '0;
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_MST_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end

            ACCESS: begin
                if (pready) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
                end
`ifdef APB_MST_TIMEOUT_EN
                // pready on the limit cycle wins, so this only runs with pready low.
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
`ifdef APB_MST_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
`ifdef APB_MST_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign paddr     = paddr_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
//   Directed and randomized bench for apb_cmd_master. The bench plays the APB
//   slave and the command/response user. Expected behaviour of every transfer is
//   computed from its cycle position after the accept edge and from the
//   read-data/error rules.
//   Inputs are driven and outputs sampled at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_apb_cmd_master;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err, busy;
    logic [ADDR_W-1:0] paddr;
    logic              psel, penable, pwrite;
    logic [DATA_W-1:0] pwdata, prdata;
    logic              pready, pslverr;

    int errors = 0;
    int checks = 0;

    apb_cmd_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 clk = ~clk;

    // Absolute time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer, entered and left at a falling edge with the DUT idle.
    //   waits     : ACCESS cycles with pready low before the pready cycle
    //   hold      : cycles rsp_ready stays low once the response is up
    //   early_rr  : rsp_ready high already during SETUP/ACCESS
    //   hold_valid: cmd_valid raised while the response is pending
    task automatic run_txn(input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input int waits,
                           input logic err, input logic [DATA_W-1:0] rd,
                           input int hold, input logic early_rr,
                           input logic hold_valid);
        logic [DATA_W-1:0] exp_pw;
        logic [DATA_W-1:0] exp_rd;
        exp_pw = w ? wd : '0;
        exp_rd = (!w && !err) ? rd : '0;

        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        rsp_ready = early_rr;
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Accept edge, then the SETUP cycle.
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_wdata = $urandom;
        check("setup_psel", psel, 1'b1);
        check("setup_penable", penable, 1'b0);
        check("setup_cmd_ready", cmd_ready, 1'b0);
        check("setup_busy", busy, 1'b1);
        check("setup_paddr", paddr, a);
        check("setup_pwrite", pwrite, w);
        check("setup_pwdata", pwdata, exp_pw);
        check("setup_rsp_valid", rsp_valid, 1'b0);
        // pready during SETUP must not shorten the transfer.
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;

        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            check("access_psel", psel, 1'b1);
            check("access_penable", penable, 1'b1);
            check("access_paddr", paddr, a);
            check("access_pwdata", pwdata, exp_pw);
            check("access_rsp_valid", rsp_valid, 1'b0);
            pready  = (i == waits);
            pslverr = (i == waits) ? err : 1'($urandom);
            prdata  = (i == waits) ? rd : $urandom;
        end

        @(negedge clk);
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, err);
        check("rsp_psel", psel, 1'b0);
        check("rsp_penable", penable, 1'b0);
        check("rsp_cmd_ready", cmd_ready, 1'b0);

        if (hold_valid) begin
            cmd_valid = 1'b1;
            cmd_addr  = ADDR_W'($urandom);
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_rdata", rsp_rdata, exp_rd);
            check("hold_rsp_err", rsp_err, err);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            check("hold_psel", psel, 1'b0);
            check("hold_paddr", paddr, a);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        check("done_rsp_valid", rsp_valid, 1'b0);
        check("done_cmd_ready", cmd_ready, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_psel", psel, 1'b0);
        check("done_paddr", paddr, a);
        check("done_pwdata", pwdata, exp_pw);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset values.
        #12;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_paddr", paddr, 8'h00);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_pwdata", pwdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait write.
        run_txn(1'b1, 8'h08, 32'hA5A5_0001, 0, 1'b0, 32'h1234_5678, 0, 1'b0, 1'b0);
        // Read with three wait states.
        run_txn(1'b0, 8'h04, 32'hFFFF_FFFF, 3, 1'b0, 32'h0000_0003, 0, 1'b0, 1'b0);
        // Read answered with a slave error.
        run_txn(1'b0, 8'hFC, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        // Response back-pressure with a new command waiting, then that command.
        run_txn(1'b0, 8'h10, 32'h0, 1, 1'b0, 32'hCAFE_0010, 5, 1'b0, 1'b1);
        run_txn(1'b1, 8'h14, 32'h0BAD_F00D, 0, 1'b0, 32'h0, 0, 1'b1, 1'b0);
        // Write with a slave error returns no data.
        run_txn(1'b1, 8'h20, 32'h5555_AAAA, 2, 1'b1, 32'h7777_7777, 1, 1'b1, 1'b0);

        // Reset pulsed in the middle of ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h30;
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(negedge clk);
        check("pre_rst_penable", penable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_psel", psel, 1'b0);
        check("async_rst_penable", penable, 1'b0);
        check("async_rst_rsp_valid", rsp_valid, 1'b0);
        check("async_rst_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_n  = 1'b1;
        pready = 1'b1;
        prdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", rsp_valid, 1'b0);
            check("post_rst_psel", psel, 1'b0);
            check("post_rst_cmd_ready", cmd_ready, 1'b1);
        end
        pready = 1'b0;
        run_txn(1'b1, 8'h34, 32'h0102_0304, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0);

        // Randomized transfers.
        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom,
                    int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                    $urandom, int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef APB_MST_TIMEOUT_EN
        // pready on the last allowed cycle completes normally.
        run_txn(1'b0, 8'h40, 32'h0, TIMEOUT_CYC - 1, 1'b0, 32'h4040_4040, 0, 1'b0, 1'b0);
        // pready stuck low: abort after TIMEOUT_CYC ACCESS cycles.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h44;
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        prdata    = 32'h9999_9999;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            @(negedge clk);
            check("to_access_psel", psel, 1'b1);
            check("to_access_penable", penable, 1'b1);
        end
        @(negedge clk);
        check("to_psel", psel, 1'b0);
        check("to_penable", penable, 1'b0);
        check("to_rsp_valid", rsp_valid, 1'b1);
        check("to_rsp_err", rsp_err, 1'b1);
        check("to_rsp_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("to_done_cmd_ready", cmd_ready, 1'b1);
        check("to_done_rsp_valid", rsp_valid, 1'b0);
`else
        // Without the abort feature a long stall still completes.
        run_txn(1'b0, 8'h48, 32'h0, 40, 1'b0, 32'h4848_4848, 0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
